// File: rtl/ast_width_extender.sv
// Avalon-ST width extender: packs N narrow input beats into one wide output word,
// with packet framing, partial-word empty calculation and single-register output stage.
module ast_width_extender #(
  parameter int DATA_IN_W   = 64,
  parameter int CHANNEL_W   = 10,
  parameter int DATA_OUT_W  = 256,
  localparam int B_IN        = DATA_IN_W / 8,
  localparam int EMPTY_IN_W  = ($clog2(B_IN) > 1) ? $clog2(B_IN) : 1,
  localparam int EMPTY_OUT_W = ($clog2(DATA_OUT_W / 8) > 1) ? $clog2(DATA_OUT_W / 8) : 1
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic [DATA_IN_W-1:0]   ast_data_i,
  input  logic                   ast_startofpacket_i,
  input  logic                   ast_endofpacket_i,
  input  logic                   ast_valid_i,
  input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
  input  logic [CHANNEL_W-1:0]   ast_channel_i,
  output logic                   ast_ready_o,
  output logic [DATA_OUT_W-1:0]  ast_data_o,
  output logic                   ast_startofpacket_o,
  output logic                   ast_endofpacket_o,
  output logic                   ast_valid_o,
  output logic [EMPTY_OUT_W-1:0] ast_empty_o,
  output logic [CHANNEL_W-1:0]   ast_channel_o,
  input  logic                   ast_ready_i
);

  localparam int N     = DATA_OUT_W / DATA_IN_W;
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] ZERO_SLOT = {CNT_W{1'b0}};

  logic [CNT_W-1:0]       r_cnt;
  logic [DATA_OUT_W-1:0]  r_buf;
  logic                   r_in_pkt;
  logic                   r_first;
  logic [CHANNEL_W-1:0]   r_chan;

  logic [DATA_OUT_W-1:0]  r_data;
  logic                   r_sop;
  logic                   r_eop;
  logic                   r_valid;
  logic [EMPTY_OUT_W-1:0] r_empty;
  logic [CHANNEL_W-1:0]   r_chan_out;

  logic                   w_take;
  logic [CNT_W-1:0]       w_slot;
  logic                   w_first;
  logic [CHANNEL_W-1:0]   w_chan;
  logic                   w_complete;
  logic [DATA_OUT_W-1:0]  w_base;
  logic [DATA_OUT_W-1:0]  w_word;
  logic [EMPTY_OUT_W-1:0] w_pad;
  logic [EMPTY_OUT_W-1:0] w_empty;

  assign ast_ready_o = !r_valid || ast_ready_i;

  // Beat steering: an SOP always restarts at slot 0 with a zeroed word; stray beats are dropped.
  always_comb begin
    w_take     = ast_valid_i && ast_ready_o && (ast_startofpacket_i || r_in_pkt);
    w_slot     = ast_startofpacket_i ? ZERO_SLOT : r_cnt;
    w_first    = ast_startofpacket_i || r_first;
    w_chan     = (w_slot == ZERO_SLOT) ? ast_channel_i : r_chan;
    w_complete = w_take && ((w_slot == LAST_SLOT) || ast_endofpacket_i);
    w_base     = (w_slot == ZERO_SLOT) ? {DATA_OUT_W{1'b0}} : r_buf;
    w_word     = w_base;
    for (int k = 0; k < N; k++) begin
      w_word[k*DATA_IN_W +: DATA_IN_W] = (w_slot == CNT_W'(k)) ? ast_data_i
                                                              : w_base[k*DATA_IN_W +: DATA_IN_W];
    end
    w_pad   = EMPTY_OUT_W'(LAST_SLOT - w_slot) * EMPTY_OUT_W'(B_IN);
    w_empty = ast_endofpacket_i ? (w_pad + EMPTY_OUT_W'(ast_empty_i)) : {EMPTY_OUT_W{1'b0}};
  end

  // Accumulation state: slot counter, partial word, packet and first-word flags.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      r_cnt    <= ZERO_SLOT;
      r_buf    <= {DATA_OUT_W{1'b0}};
      r_in_pkt <= 1'b0;
      r_first  <= 1'b0;
      r_chan   <= {CHANNEL_W{1'b0}};
    end else if (w_complete) begin
      r_cnt    <= ZERO_SLOT;
      r_buf    <= w_word;
      r_in_pkt <= !ast_endofpacket_i;
      r_first  <= 1'b0;
      r_chan   <= w_chan;
    end else if (w_take) begin
      r_cnt    <= w_slot + CNT_W'(1);
      r_buf    <= w_word;
      r_in_pkt <= 1'b1;
      r_first  <= w_first;
      r_chan   <= w_chan;
    end
  end

  // Output register: loads a finished word, otherwise holds until the sink takes it.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      r_data     <= {DATA_OUT_W{1'b0}};
      r_sop      <= 1'b0;
      r_eop      <= 1'b0;
      r_valid    <= 1'b0;
      r_empty    <= {EMPTY_OUT_W{1'b0}};
      r_chan_out <= {CHANNEL_W{1'b0}};
    end else if (w_complete) begin
      r_data     <= w_word;
      r_sop      <= w_first;
      r_eop      <= ast_endofpacket_i;
      r_valid    <= 1'b1;
      r_empty    <= w_empty;
      r_chan_out <= w_chan;
    end else if (ast_ready_i) begin
      r_valid    <= 1'b0;
    end
  end

  assign ast_data_o          = r_data;
  assign ast_startofpacket_o = r_sop;
  assign ast_endofpacket_o   = r_eop;
  assign ast_valid_o         = r_valid;
  assign ast_empty_o         = r_empty;
  assign ast_channel_o       = r_chan_out;

endmodule

// File: tb/tb_ast_width_extender.sv
// Directed bench for ast_width_extender at default parameters (N=4, B_IN=8).
module tb_ast_width_extender;

  logic         clk_i = 1'b0;
  logic         srst_i;
  logic [63:0]  ast_data_i;
  logic         ast_startofpacket_i;
  logic         ast_endofpacket_i;
  logic         ast_valid_i;
  logic [2:0]   ast_empty_i;
  logic [9:0]   ast_channel_i;
  logic         ast_ready_o;
  logic [255:0] ast_data_o;
  logic         ast_startofpacket_o;
  logic         ast_endofpacket_o;
  logic         ast_valid_o;
  logic [4:0]   ast_empty_o;
  logic [9:0]   ast_channel_o;
  logic         ast_ready_i;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] w [0:5];
  logic [63:0] zero64;

  ast_width_extender dut (
    .clk_i(clk_i), .srst_i(srst_i),
    .ast_data_i(ast_data_i), .ast_startofpacket_i(ast_startofpacket_i),
    .ast_endofpacket_i(ast_endofpacket_i), .ast_valid_i(ast_valid_i),
    .ast_empty_i(ast_empty_i), .ast_channel_i(ast_channel_i),
    .ast_ready_o(ast_ready_o), .ast_data_o(ast_data_o),
    .ast_startofpacket_o(ast_startofpacket_o), .ast_endofpacket_o(ast_endofpacket_o),
    .ast_valid_o(ast_valid_o), .ast_empty_o(ast_empty_o),
    .ast_channel_o(ast_channel_o), .ast_ready_i(ast_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] d, input logic sop, input logic eop,
                      input logic [2:0] emp, input logic [9:0] ch);
    ast_data_i = d; ast_startofpacket_i = sop; ast_endofpacket_i = eop;
    ast_empty_i = emp; ast_channel_i = ch; ast_valid_i = 1'b1;
    @(posedge clk_i); #1;
    ast_valid_i = 1'b0; ast_startofpacket_i = 1'b0; ast_endofpacket_i = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk_i); #1;
  endtask

  task automatic chk_word(input string tag, input logic [255:0] d, input logic sop,
                          input logic eop, input logic [4:0] emp, input logic [9:0] ch);
    chk({tag, ".valid"}, {255'd0, ast_valid_o}, 256'd1);
    chk({tag, ".data"}, ast_data_o, d);
    chk({tag, ".sop"}, {255'd0, ast_startofpacket_o}, {255'd0, sop});
    chk({tag, ".eop"}, {255'd0, ast_endofpacket_o}, {255'd0, eop});
    chk({tag, ".empty"}, {251'd0, ast_empty_o}, {251'd0, emp});
    chk({tag, ".chan"}, {246'd0, ast_channel_o}, {246'd0, ch});
  endtask

  initial begin
    zero64 = 64'd0;
    w[0] = 64'h0123_4567_89AB_CDEF; w[1] = 64'hFEDC_BA98_7654_3210;
    w[2] = 64'hA5A5_5A5A_0F0F_F0F0; w[3] = 64'h1111_2222_3333_4444;
    w[4] = 64'hDEAD_BEEF_CAFE_F00D; w[5] = 64'h8000_0000_0000_0001;
    srst_i = 1'b1; ast_ready_i = 1'b1; ast_valid_i = 1'b0;
    ast_data_i = 64'd0; ast_startofpacket_i = 1'b0; ast_endofpacket_i = 1'b0;
    ast_empty_i = 3'd0; ast_channel_i = 10'd0;

    // Reset state
    repeat (2) @(posedge clk_i); #1;
    chk("rst.valid", {255'd0, ast_valid_o}, 256'd0);
    chk("rst.data", ast_data_o, 256'd0);
    chk("rst.flags", {252'd0, ast_startofpacket_o, ast_endofpacket_o, 2'b00}, 256'd0);
    chk("rst.empty_chan", {241'd0, ast_empty_o, ast_channel_o}, 256'd0);
    srst_i = 1'b0; #1;
    chk("rst.ready", {255'd0, ast_ready_o}, 256'd1);

    // Full 4-beat packet; non-EOP empty values must be ignored
    send(w[0], 1'b1, 1'b0, 3'd0, 10'h055);
    send(w[1], 1'b0, 1'b0, 3'd7, 10'h0AA);
    send(w[2], 1'b0, 1'b0, 3'd2, 10'h0AA);
    chk("p4.no_early", {255'd0, ast_valid_o}, 256'd0);
    send(w[3], 1'b0, 1'b1, 3'd0, 10'h0AA);
    chk_word("p4", {w[3], w[2], w[1], w[0]}, 1'b1, 1'b1, 5'd0, 10'h055);
    idle();
    chk("p4.drop", {255'd0, ast_valid_o}, 256'd0);

    // 6-beat packet, second word partial with empty 3
    send(w[0], 1'b1, 1'b0, 3'd0, 10'h133);
    send(w[1], 1'b0, 1'b0, 3'd0, 10'h133);
    send(w[2], 1'b0, 1'b0, 3'd0, 10'h133);
    send(w[3], 1'b0, 1'b0, 3'd0, 10'h133);
    chk_word("p6w1", {w[3], w[2], w[1], w[0]}, 1'b1, 1'b0, 5'd0, 10'h133);
    send(w[4], 1'b0, 1'b0, 3'd0, 10'h1AB);
    chk("p6.gap", {255'd0, ast_valid_o}, 256'd0);
    send(w[5], 1'b0, 1'b1, 3'd3, 10'h3FF);
    chk_word("p6w2", {zero64, zero64, w[5], w[4]}, 1'b0, 1'b1, 5'd19, 10'h1AB);
    idle();

    // Single SOP+EOP beat
    send(w[2], 1'b1, 1'b1, 3'd5, 10'h2A5);
    chk_word("p1", {zero64, zero64, zero64, w[2]}, 1'b1, 1'b1, 5'd29, 10'h2A5);
    idle();

    // Stray beats outside a packet are discarded
    send(w[4], 1'b0, 1'b0, 3'd0, 10'h001);
    send(w[5], 1'b0, 1'b1, 3'd1, 10'h001);
    idle();
    chk("stray.none", {255'd0, ast_valid_o}, 256'd0);

    // Mid-packet SOP restarts at slot 0
    send(w[0], 1'b1, 1'b0, 3'd0, 10'h011);
    send(w[1], 1'b0, 1'b0, 3'd0, 10'h011);
    send(w[4], 1'b1, 1'b0, 3'd0, 10'h022);
    send(w[5], 1'b0, 1'b1, 3'd0, 10'h033);
    chk_word("resop", {zero64, zero64, w[5], w[4]}, 1'b1, 1'b1, 5'd16, 10'h022);
    idle();

    // Backpressure: word held, sink stalled, then resumes on ready
    ast_ready_i = 1'b0;
    send(w[3], 1'b1, 1'b0, 3'd0, 10'h100);
    send(w[2], 1'b0, 1'b0, 3'd0, 10'h100);
    send(w[1], 1'b0, 1'b0, 3'd0, 10'h100);
    send(w[0], 1'b0, 1'b1, 3'd0, 10'h100);
    chk("bp.ready_low", {255'd0, ast_ready_o}, 256'd0);
    ast_data_i = w[5]; ast_startofpacket_i = 1'b1; ast_endofpacket_i = 1'b0;
    ast_empty_i = 3'd0; ast_channel_i = 10'h200; ast_valid_i = 1'b1;
    idle();
    idle();
    chk_word("bp.hold", {w[0], w[1], w[2], w[3]}, 1'b1, 1'b1, 5'd0, 10'h100);
    chk("bp.ready_still_low", {255'd0, ast_ready_o}, 256'd0);
    ast_ready_i = 1'b1; #1;
    chk("bp.ready_comb", {255'd0, ast_ready_o}, 256'd1);
    @(posedge clk_i); #1;
    ast_valid_i = 1'b0; ast_startofpacket_i = 1'b0;
    chk("bp.transfer", {255'd0, ast_valid_o}, 256'd0);
    send(w[4], 1'b0, 1'b0, 3'd0, 10'h201);
    send(w[3], 1'b0, 1'b0, 3'd0, 10'h201);
    send(w[2], 1'b0, 1'b1, 3'd0, 10'h201);
    chk_word("bp.resume", {w[2], w[3], w[4], w[5]}, 1'b1, 1'b1, 5'd0, 10'h200);

    // Reset mid-packet: partial packet discarded, outputs cleared asynchronously
    send(w[0], 1'b1, 1'b0, 3'd0, 10'h0F0);
    send(w[1], 1'b0, 1'b0, 3'd0, 10'h0F0);
    srst_i = 1'b1; #2;
    chk("arst.data", ast_data_o, 256'd0);
    chk("arst.ctl", {241'd0, ast_valid_o, ast_startofpacket_o, ast_endofpacket_o,
                     ast_empty_o, ast_channel_o, 2'b00}, 256'd0);
    #2 srst_i = 1'b0;
    @(posedge clk_i); #1;
    send(w[2], 1'b0, 1'b1, 3'd0, 10'h0F0);
    idle();
    chk("arst.no_partial", {255'd0, ast_valid_o}, 256'd0);
    send(w[5], 1'b1, 1'b0, 3'd0, 10'h3C3);
    send(w[4], 1'b0, 1'b0, 3'd0, 10'h3C3);
    send(w[3], 1'b0, 1'b0, 3'd0, 10'h3C3);
    chk("arst.no_early", {255'd0, ast_valid_o}, 256'd0);
    send(w[2], 1'b0, 1'b1, 3'd0, 10'h3C3);
    chk_word("arst.new", {w[2], w[3], w[4], w[5]}, 1'b1, 1'b1, 5'd0, 10'h3C3);
    idle();
    chk("arst.single", {255'd0, ast_valid_o}, 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ast_width_extender.md
AST_WIDTH_EXTENDER -- requirements
Module: ast_width_extender

Interface
REQ-001 SHALL have parameter DATA_IN_W, default 64, input data width in bits; a multiple of 8.
REQ-002 SHALL have parameter CHANNEL_W, default 10, channel field width in bits.
REQ-003 SHALL have parameter DATA_OUT_W, default 256, output data width in bits; DATA_OUT_W/DATA_IN_W = N, a power of 2 and at least 2.
REQ-004 SHALL derive localparams: B_IN = DATA_IN_W/8; EMPTY_IN_W = max(1, clog2(B_IN)); EMPTY_OUT_W = max(1, clog2(DATA_OUT_W/8)).
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 SHALL have port srst_i, input, 1 bit: reset; asynchronous, active-high.
REQ-007 SHALL have ports ast_data_i [DATA_IN_W], ast_startofpacket_i [1], ast_endofpacket_i [1], ast_valid_i [1], ast_empty_i [EMPTY_IN_W] and ast_channel_i [CHANNEL_W], all inputs: the Avalon-ST sink.
REQ-008 SHALL have port ast_ready_o, output, 1 bit: sink ready.
REQ-009 SHALL have ports ast_data_o [DATA_OUT_W], ast_startofpacket_o [1], ast_endofpacket_o [1], ast_valid_o [1], ast_empty_o [EMPTY_OUT_W] and ast_channel_o [CHANNEL_W], all outputs: the Avalon-ST source.
REQ-010 SHALL have port ast_ready_i, input, 1 bit: source ready.

Function
REQ-011 An input beat SHALL be accepted when ast_valid_i and ast_ready_o are both 1; an output beat SHALL be transferred when ast_valid_o and ast_ready_i are both 1.
REQ-012 ast_ready_o SHALL equal (!ast_valid_o || ast_ready_i), combinationally.
REQ-013 Accepted beats SHALL be packed into an accumulation buffer:
- the k-th beat of an output word goes to bits [k*DATA_IN_W +: DATA_IN_W];
- the first beat goes to the LSBs.
REQ-014 A word counter, 0..N-1, SHALL increment on each accepted in-packet beat and wrap to 0 when an output word is completed.
REQ-015 An output word SHALL complete on the accepted beat where the counter equals N-1, or on the accepted beat with ast_endofpacket_i=1, whichever comes first.
REQ-016 On completion, the assembled word SHALL be registered onto ast_data_o with ast_valid_o=1 on the next clock edge (latency 1 cycle after the last beat).
REQ-017 Unfilled input-word slots of a partial (EOP) word SHALL be driven as zero.
REQ-018 ast_empty_o SHALL be 0 for non-EOP words, and (N-1-k)*B_IN + ast_empty_i for the EOP word, where k is the slot index of the EOP beat.
REQ-019 ast_empty_i SHALL be ignored on beats that are not EOP.
REQ-020 ast_startofpacket_o SHALL be 1 only on the first output word of a packet.
REQ-021 ast_endofpacket_o SHALL be 1 only on the word containing the input EOP beat.
REQ-022 ast_channel_o SHALL carry the ast_channel_i value captured on the first beat of that output word.
REQ-023 A beat with both SOP and EOP set SHALL produce exactly one output word with SOP=EOP=1.
REQ-024 A valid beat that arrives outside a packet without SOP SHALL be accepted and discarded.
REQ-025 A SOP beat that arrives mid-packet SHALL discard the partial buffer and start a new packet at slot 0.
REQ-026 While ast_valid_o=1 and ast_ready_i=0, all ast_*_o outputs SHALL hold stable.
REQ-027 After a transfer with no new completion, ast_valid_o SHALL drop to 0 on the next edge.

Reset
REQ-028 While srst_i=1 (asynchronous), all ast_*_o data, empty, channel, SOP, EOP and valid outputs SHALL be 0, and the counter, buffer and in-packet flag SHALL clear.
REQ-029 After reset deassertion, ast_ready_o SHALL be 1.
REQ-030 A packet in progress at reset SHALL be discarded entirely; no partial word is emitted.

Verification (defaults: N=4, B_IN=8, EMPTY_OUT_W=5)
REQ-031 Reset: srst_i pulsed -> all outputs 0; ast_ready_o=1 after release.
REQ-032 4-beat packet, words W0..W3, ast_empty_i=0, ast_ready_i=1 -> one beat: data {W3,W2,W1,W0}, SOP=1, EOP=1, empty=0, one cycle after W3.
REQ-033 6-beat packet, last ast_empty_i=3 -> word 1: SOP=1, EOP=0, empty=0; word 2: data {0,0,W5,W4}, EOP=1, empty=19.
REQ-034 Single beat with SOP+EOP, ast_empty_i=5, channel 0x2A5 -> data {0,0,0,W0}, empty=29, channel 0x2A5.
REQ-035 Backpressure: ast_ready_i=0 while ast_valid_o=1 -> ast_ready_o=0 and outputs stable; on ast_ready_i=1 the transfer occurs and input resumes.
REQ-036 Reset asserted after 2 beats of a packet, then a new 4-beat packet -> exactly one output word, containing only the new packet's data.
